// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter
//   Two-port arbiter and sequencer for the 16x4 data memory. After reset it
//   zero-fills every memory word. It then serves one single-cycle access at a
//   time: port A is the core/datapath and port B is the loader/debug port.
//   Each access runs IDLE -> ACCESS -> RESP, so a request sampled at edge n
//   gives ACCESS in cycle n+1 and the ack pulse in cycle n+2.
//
//   Optional build macro: MEMARB_FIXED_PRI_EN
//     defined   : port A always wins a tie, and port B can starve.
//     undefined : ties alternate between the ports (round-robin).
//
// Ports
//   clk                     system clock, rising edge
//   reset                   asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata   port A request fields
//   a_ack, a_rdata              port A one-cycle completion pulse and read data
//   b_*                         same set of signals for port B
//   mem_address/mem_write/mem_data_in   memory control, all registered
//   mem_data_out                memory combinational read data
//   init_done                   high once the zero-fill sweep has completed
//   busy                        high in every state except IDLE
//   state_dbg                   current FSM state (0 INIT, 1 IDLE, 2 ACCESS, 3 RESP)
module data_memory_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              init_done,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  // Handshake: a requester raises req and holds we/addr/wdata stable until it
  // sees its one-cycle ack. Requests are sampled only in IDLE. Because RESP
  // never samples, a requester may drop req or present new fields during the
  // ack cycle.

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] sweep_cnt;
  logic              win_b;        // winner of the current access: 0 = A, 1 = B
  logic              grant_a;
  logic              grant_b;

  assign state_dbg = state;

`ifdef MEMARB_FIXED_PRI_EN
  always_comb begin
    grant_a = a_req;
    grant_b = b_req & ~a_req;
  end
`else
  logic last_grant;              // 0 = A, 1 = B; on a tie, the other port wins

  always_comb begin
    grant_a = a_req & (~b_req | last_grant);
    grant_b = b_req & (~a_req | ~last_grant);
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_INIT;
      sweep_cnt   <= '0;
`ifndef MEMARB_FIXED_PRI_EN
      last_grant  <= 1'b1;
`endif
      win_b       <= 1'b0;
      // These values are the first INIT cycle: write 0 to address 0.
      mem_address <= '0;
      mem_write   <= 1'b1;
      mem_data_in <= '0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
      init_done   <= 1'b0;
      busy        <= 1'b1;
    end else begin
      case (state)
        ST_INIT: begin
          if (sweep_cnt == '1) begin
            state       <= ST_IDLE;
            mem_write   <= 1'b0;
            mem_address <= '0;
            init_done   <= 1'b1;
            busy        <= 1'b0;
          end else begin
            sweep_cnt   <= sweep_cnt + 1'b1;
            mem_address <= sweep_cnt + 1'b1;
          end
        end

        ST_IDLE: begin
          if (grant_a || grant_b) begin
            state       <= ST_ACCESS;
            busy        <= 1'b1;
            win_b       <= grant_b;
`ifndef MEMARB_FIXED_PRI_EN
            last_grant  <= grant_b;
`endif
            // mem_write itself serves as the latched 'we' during ACCESS.
            mem_address <= grant_b ? b_addr : a_addr;
            mem_write   <= grant_b ? b_we : a_we;
            if (grant_b)
              mem_data_in <= b_we ? b_wdata : '0;
            else
              mem_data_in <= a_we ? a_wdata : '0;
          end
        end

        ST_ACCESS: begin
          state <= ST_RESP;
          // The read data is valid only while mem_write is low.
          if (!mem_write) begin
            if (win_b) b_rdata <= mem_data_out;
            else       a_rdata <= mem_data_out;
          end
          if (win_b) b_ack <= 1'b1;
          else       a_ack <= 1'b1;
          mem_address <= '0;
          mem_write   <= 1'b0;
          mem_data_in <= '0;
        end

        ST_RESP: begin
          state <= ST_IDLE;
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          busy  <= 1'b0;
        end

        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed testbench for data_memory_arbiter. It includes a behavioural
// 16x4 memory with a combinational read and a write on the clock edge.
module tb_data_memory_arbiter;

  localparam int AW = 4;
  localparam int DW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          a_req = 1'b0, a_we = 1'b0, a_ack;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0, a_rdata;
  logic          b_req = 1'b0, b_we = 1'b0, b_ack;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0, b_rdata;
  logic [AW-1:0] mem_address;
  logic          mem_write;
  logic [DW-1:0] mem_data_in, mem_data_out;
  logic          init_done, busy;
  logic [1:0]    state_dbg;

  data_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_address(mem_address), .mem_write(mem_write),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .init_done(init_done), .busy(busy), .state_dbg(state_dbg)
  );

  // Memory model. 'scramble' preloads nonzero junk so the zero-fill is visible.
  logic          scramble = 1'b0;
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < 16; i++) mem[i] <= 4'(i) | 4'h8;
    end else if (mem_write) begin
      mem[mem_address] <= mem_data_in;
    end
  end
  assign mem_data_out = mem[mem_address];

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [DW:0] exp_q[$];   // {port (1 = B), expected rdata}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // The task returns at the negedge of the ack cycle. It drops req there.
  // 'lat' counts negedges from the request launch up to and including the ack
  // cycle. When the DUT is IDLE this is 3: the sample cycle, ACCESS, then RESP.
  task automatic access(input bit port, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata,
                        output logic [DW-1:0] rdata, output int lat);
    bit got;
    @(posedge clk); #1;
    if (port) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wdata; end
    else      begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wdata; end
    got = 0;
    lat = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (port ? b_ack : a_ack) got = 1;
    end
    rdata = port ? b_rdata : a_rdata;
    if (!got) check("ack_timeout", 0, 1);
    else      check("other_ack_quiet", 32'(port ? a_ack : b_ack), 0);
    if (port) b_req = 0; else a_req = 0;
  endtask

  task automatic wait_init();
    for (int i = 0; i < 40 && !init_done; i++) @(negedge clk);
    check("init_done_reached", 32'(init_done), 1);
  endtask

  logic [DW-1:0] rd, a_keep;
  int lat, acks, last_t, t, early, a_seen;
  logic [DW:0] obs, expv;

  initial begin
    // ---- reset state and zero-fill ----
    reset = 0;
    scramble = 1;
    @(negedge clk);
    scramble = 0;
    @(negedge clk);
    check("rst_state", 32'(state_dbg), 0);
    check("rst_busy", 32'(busy), 1);
    check("rst_init_done", 32'(init_done), 0);
    check("rst_acks", 32'({a_ack, b_ack}), 0);
    check("rst_rdata", 32'({a_rdata, b_rdata}), 0);
    check("rst_mem_write", 32'(mem_write), 1);
    reset = 1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check($sformatf("init_done_k%0d", k), 32'(init_done), (k == 16) ? 1 : 0);
    end
    check("idle_busy", 32'(busy), 0);
    for (int i = 0; i < 16; i++) begin
      access(0, 0, 4'(i), 4'h0, rd, lat);
      check($sformatf("zero_fill_%0d", i), 32'(rd), 0);
      if (i == 0) check("read_latency", 32'(lat), 3);
    end

    // ---- write then read across ports ----
    access(0, 1, 4'd5, 4'hA, rd, lat);
    check("write_latency", 32'(lat), 3);
    access(0, 1, 4'd6, 4'h3, rd, lat);
    access(0, 0, 4'd6, 4'h0, rd, lat);
    check("a_read6", 32'(rd), 32'h3);
    access(1, 0, 4'd5, 4'h0, rd, lat);
    check("b_read5", 32'(rd), 32'hA);
    check("a_rdata_kept_b_read", 32'(a_rdata), 32'h3);
    access(1, 1, 4'd6, 4'h9, rd, lat);
    check("b_rdata_kept_write", 32'(b_rdata), 32'hA);
    check("a_rdata_kept_b_write", 32'(a_rdata), 32'h3);
    access(0, 0, 4'd6, 4'h0, rd, lat);
    check("a_read6_after_b", 32'(rd), 32'h9);

    // ---- a request during INIT is held off until the sweep has completed ----
    reset = 0;
    @(negedge clk);
    reset = 1;
    a_req = 1; a_we = 1; a_addr = 4'd0; a_wdata = 4'hF;
    early = 0; a_seen = 0; t = 0;
    for (int i = 0; i < 60 && !a_seen; i++) begin
      @(negedge clk);
      t++;
      if (a_ack && !init_done) early++;
      if (a_ack) a_seen = 1;
    end
    check("init_block_ack_seen", 32'(a_seen), 1);
    check("init_block_no_early", 32'(early), 0);
    check("init_block_ack_cycle", 32'(t), 18);
    a_req = 0; a_we = 0;
    access(0, 0, 4'd0, 4'h0, rd, lat);
    check("init_block_read0", 32'(rd), 32'hF);

    // ---- reset during ACCESS ----
    a_keep = a_rdata;
    check("pre_abort_a_rdata", 32'(a_keep), 32'hF);
    @(posedge clk); #1;
    a_req = 1; a_we = 1; a_addr = 4'd9; a_wdata = 4'h6;
    for (int i = 0; i < 10 && state_dbg != 2'd2; i++) @(negedge clk);
    check("abort_in_access", 32'(state_dbg), 2);
    reset = 0;
    #1;
    check("abort_ack", 32'({a_ack, b_ack}), 0);
    check("abort_rdata", 32'(a_rdata), 0);
    check("abort_state", 32'(state_dbg), 0);
    check("abort_init_done", 32'(init_done), 0);
    a_req = 0; a_we = 0;
    @(negedge clk);
    reset = 1;
    acks = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (a_ack) acks++;
    end
    check("abort_no_ack", 32'(acks), 0);
    check("abort_resweep_done", 32'(init_done), 1);
    access(0, 0, 4'd9, 4'h0, rd, lat);
    check("abort_no_write", 32'(rd), 0);

    // ---- contention ----
    access(1, 1, 4'd3, 4'hC, rd, lat);
    access(1, 1, 4'd7, 4'h5, rd, lat);   // last grant is now B
    for (int i = 0; i < 6; i++) begin
`ifdef MEMARB_FIXED_PRI_EN
      exp_q.push_back({1'b0, 4'hC});
`else
      exp_q.push_back((i % 2 == 0) ? {1'b0, 4'hC} : {1'b1, 4'h5});
`endif
    end
    @(posedge clk); #1;
    a_req = 1; a_we = 0; a_addr = 4'd3;
    b_req = 1; b_we = 0; b_addr = 4'd7;
    acks = 0; last_t = 0; t = 0;
    for (int i = 0; i < 60 && acks < 6; i++) begin
      @(negedge clk);
      t++;
      if (a_ack || b_ack) begin
        check("cont_single_ack", 32'(a_ack & b_ack), 0);
        obs = b_ack ? {1'b1, b_rdata} : {1'b0, a_rdata};
        if (exp_q.size() == 0) begin
          check("cont_queue_empty", 32'(obs), 0);
        end else begin
          expv = exp_q.pop_front();
          check($sformatf("cont_grant_%0d", acks), 32'(obs), 32'(expv));
        end
        if (acks > 0) check("cont_spacing", 32'(t - last_t), 3);
        last_t = t;
        acks++;
      end
    end
    check("cont_ack_count", 32'(acks), 6);
    a_req = 0;
`ifdef MEMARB_FIXED_PRI_EN
    a_seen = 0;
    for (int i = 0; i < 10 && !a_seen; i++) begin
      @(negedge clk);
      if (b_ack) a_seen = 1;
    end
    check("fixed_b_after_a_drop", 32'(a_seen), 1);
    check("fixed_b_rdata", 32'(b_rdata), 32'h5);
`endif
    b_req = 0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
